// File: rtl/mcu_uart_cmd_rx.sv
// rtl/mcu_uart_cmd_rx.sv - 8N1 UART receiver and MCU command decoder (PTT, shutdown, aux byte)
module mcu_uart_cmd_rx #(
    parameter int CLKS_PER_BIT     = 6400,
    parameter int ARG_TIMEOUT_CLKS = 1228800
) (
    input  logic       clk,
    input  logic       i_Rst_L,
    input  logic       mcu_uart_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_dv,
    output logic       o_frame_err,
    output logic       o_ptt_req,
    output logic       o_shutdown_req,
    output logic [7:0] o_aux,
    output logic       o_aux_valid,
    output logic       o_cmd_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int TW = $clog2(ARG_TIMEOUT_CLKS) + 1;

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(ARG_TIMEOUT_CLKS - 1);

    localparam logic [7:0] OP_PTT_ON  = 8'h25;
    localparam logic [7:0] OP_PTT_OFF = 8'h26;
    localparam logic [7:0] OP_SHUTDN  = 8'h27;
    localparam logic [7:0] OP_AUX     = 8'h28;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        CMD_WAIT,
        ARG_WAIT
    } cmd_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_s;

    // Two-flop synchroniser; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    // Synchroniser shift path.
    always_comb begin
        rx_meta_d = mcu_uart_rx;
        rx_s_d    = rx_meta_q;
    end

    assign rx_s = rx_s_q;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_dv_q, rx_dv_d;
    logic            frame_err_q, frame_err_d;

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Receiver next-state: start qualification at mid-bit, 8 data bits, stop check.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_END) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (cnt_q == BIT_END && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit counter, LSB-first shift, byte/frame-error pulses.
    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            RX_START: begin
                if (cnt_q == HALF_END) cnt_d = '0;
                else                   cnt_d = cnt_q + CW'(1);
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_byte_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command decoder FSM
    // ------------------------------------------------------------------
    cmd_state_t    cmd_state_q, cmd_state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0] tmo_inc;
    logic          tmo_hit;
    logic          ptt_q, ptt_d;
    logic          shutdown_q, shutdown_d;
    logic [7:0]    aux_q, aux_d;
    logic          aux_valid_q, aux_valid_d;
    logic          cmd_err_q, cmd_err_d;

    // The timeout fires on the edge where the counter would reach its limit,
    // which places o_cmd_err exactly ARG_TIMEOUT_CLKS cycles after the
    // opcode's o_rx_dv.
    assign tmo_inc = tmo_cnt_q + TW'(1);
    assign tmo_hit = (tmo_inc == TMO_END);

    // Decoder state and output registers.
    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cmd_state_q <= CMD_WAIT;
            tmo_cnt_q   <= '0;
            ptt_q       <= 1'b0;
            shutdown_q  <= 1'b0;
            aux_q       <= '0;
            aux_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_state_q <= cmd_state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ptt_q       <= ptt_d;
            shutdown_q  <= shutdown_d;
            aux_q       <= aux_d;
            aux_valid_q <= aux_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Decoder next-state: an arrived byte beats a simultaneous timeout.
    always_comb begin
        cmd_state_d = cmd_state_q;
        case (cmd_state_q)
            CMD_WAIT: begin
                if (rx_dv_q && rx_byte_q == OP_AUX) cmd_state_d = ARG_WAIT;
            end
            ARG_WAIT: begin
                if (rx_dv_q || frame_err_d || tmo_hit) cmd_state_d = CMD_WAIT;
            end
            default: cmd_state_d = CMD_WAIT;
        endcase
    end

    // Decoder outputs. A framing error while waiting for the argument is seen
    // on the detection cycle so o_cmd_err lines up with o_frame_err.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        ptt_d       = ptt_q;
        shutdown_d  = 1'b0;
        aux_d       = aux_q;
        aux_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        case (cmd_state_q)
            CMD_WAIT: begin
                tmo_cnt_d = '0;
                if (rx_dv_q) begin
                    case (rx_byte_q)
                        OP_PTT_ON:  ptt_d      = 1'b1;
                        OP_PTT_OFF: ptt_d      = 1'b0;
                        OP_SHUTDN:  shutdown_d = 1'b1;
                        OP_AUX:     tmo_cnt_d  = '0;
                        default:    cmd_err_d  = 1'b1;
                    endcase
                end
            end
            ARG_WAIT: begin
                if (rx_dv_q) begin
                    aux_d       = rx_byte_q;
                    aux_valid_d = 1'b1;
                    tmo_cnt_d   = '0;
                end else if (frame_err_d || tmo_hit) begin
                    cmd_err_d = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            default: tmo_cnt_d = '0;
        endcase
    end

    assign o_rx_byte      = rx_byte_q;
    assign o_rx_dv        = rx_dv_q;
    assign o_frame_err    = frame_err_q;
    assign o_ptt_req      = ptt_q;
    assign o_shutdown_req = shutdown_q;
    assign o_aux          = aux_q;
    assign o_aux_valid    = aux_valid_q;
    assign o_cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_mcu_uart_cmd_rx.sv
// tb/tb_mcu_uart_cmd_rx.sv - directed scoreboard bench for mcu_uart_cmd_rx
module tb_mcu_uart_cmd_rx;

    localparam int BIT = 16;
    localparam int TMO = 400;

    logic       clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       mcu_uart_rx = 1'b1;
    logic [7:0] o_rx_byte;
    logic       o_rx_dv;
    logic       o_frame_err;
    logic       o_ptt_req;
    logic       o_shutdown_req;
    logic [7:0] o_aux;
    logic       o_aux_valid;
    logic       o_cmd_err;

    mcu_uart_cmd_rx #(
        .CLKS_PER_BIT     (BIT),
        .ARG_TIMEOUT_CLKS (TMO)
    ) dut (
        .clk            (clk),
        .i_Rst_L        (i_Rst_L),
        .mcu_uart_rx    (mcu_uart_rx),
        .o_rx_byte      (o_rx_byte),
        .o_rx_dv        (o_rx_dv),
        .o_frame_err    (o_frame_err),
        .o_ptt_req      (o_ptt_req),
        .o_shutdown_req (o_shutdown_req),
        .o_aux          (o_aux),
        .o_aux_valid    (o_aux_valid),
        .o_cmd_err      (o_cmd_err)
    );

    always #5 clk = ~clk;

    // Monitor state (written only by the monitor).
    logic [7:0] obs_q[$];
    int cyc = 0;
    int dv_cnt = 0, fe_cnt = 0, ce_cnt = 0, av_cnt = 0, sd_cnt = 0;
    int dv_cyc = 0, fe_cyc = 0, ce_cyc = 0;
    int stretch = 0;
    logic ptt_at_dv = 1'b0, ptt_after_dv = 1'b0;
    logic p_dv = 1'b0, p_fe = 1'b0, p_ce = 1'b0, p_av = 1'b0, p_sd = 1'b0;

    // Scoreboard/checker state (written only by the stimulus block).
    logic [7:0] exp_q[$];
    int nchk = 0;
    int nfail = 0;

    always @(negedge clk) begin
        cyc++;
        if (p_dv) ptt_after_dv = o_ptt_req;
        if (o_rx_dv) begin
            obs_q.push_back(o_rx_byte);
            dv_cnt++;
            dv_cyc = cyc;
            ptt_at_dv = o_ptt_req;
        end
        if (o_frame_err)    begin fe_cnt++; fe_cyc = cyc; end
        if (o_cmd_err)      begin ce_cnt++; ce_cyc = cyc; end
        if (o_aux_valid)    av_cnt++;
        if (o_shutdown_req) sd_cnt++;
        if ((o_rx_dv && p_dv) || (o_frame_err && p_fe) || (o_cmd_err && p_ce) ||
            (o_aux_valid && p_av) || (o_shutdown_req && p_sd)) stretch++;
        p_dv = o_rx_dv; p_fe = o_frame_err; p_ce = o_cmd_err;
        p_av = o_aux_valid; p_sd = o_shutdown_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        if (stop_v) exp_q.push_back(b);
        mcu_uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mcu_uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        mcu_uart_rx = stop_v;
        repeat (BIT) @(negedge clk);
        mcu_uart_rx = 1'b1;
    endtask

    task automatic sb_check(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                check({tag, "_missing"}, 32'hDEAD, {24'h0, e});
            end else begin
                o = obs_q.pop_front();
                check({tag, "_byte"}, {24'h0, o}, {24'h0, e});
            end
        end
        check({tag, "_extra"}, obs_q.size(), 0);
    endtask

    int dv0, fe0, ce0, av0, sd0;
    int waited;

    initial begin
        idle(5);
        check("rst_dv",   o_rx_dv, 0);
        check("rst_outs", {o_rx_byte, o_aux, o_frame_err, o_ptt_req, o_shutdown_req,
                           o_aux_valid, o_cmd_err}, 0);
        i_Rst_L = 1'b1;
        idle(10);

        // 1: PTT on / off
        ce0 = ce_cnt;
        send_byte(8'h25, 1'b1);
        idle(4);
        check("ptt_on_at_dv", ptt_at_dv, 0);
        check("ptt_on_next",  ptt_after_dv, 1);
        check("ptt_on_level", o_ptt_req, 1);
        send_byte(8'h26, 1'b1);
        idle(4);
        check("ptt_off", o_ptt_req, 0);
        check("t1_no_cmd_err", ce_cnt, ce0);
        sb_check("t1");

        // 2: aux argument back-to-back, argument not decoded as opcode
        av0 = av_cnt;
        send_byte(8'h28, 1'b1);
        send_byte(8'hA7, 1'b1);
        idle(4);
        check("aux_a7", o_aux, 8'hA7);
        check("aux_a7_pulses", av_cnt - av0, 1);
        check("aux_a7_ptt", o_ptt_req, 0);
        send_byte(8'h28, 1'b1);
        send_byte(8'h25, 1'b1);
        idle(4);
        check("aux_25", o_aux, 8'h25);
        check("aux_25_ptt", o_ptt_req, 0);
        check("aux_25_pulses", av_cnt - av0, 2);
        sb_check("t2");

        // 3: start-bit glitches 1..7 cycles rejected
        dv0 = dv_cnt; fe0 = fe_cnt; ce0 = ce_cnt;
        for (int g = 1; g <= 7; g++) begin
            mcu_uart_rx = 1'b0;
            idle(g);
            mcu_uart_rx = 1'b1;
            idle(40);
        end
        check("glitch_dv", dv_cnt, dv0);
        check("glitch_fe", fe_cnt, fe0);
        check("glitch_ce", ce_cnt, ce0);

        // 4: framing error then held-low line, then shutdown
        fe0 = fe_cnt; ce0 = ce_cnt; sd0 = sd_cnt;
        send_byte(8'h55, 1'b0);
        mcu_uart_rx = 1'b0;
        idle(100);
        mcu_uart_rx = 1'b1;
        idle(20);
        check("break_fe_once", fe_cnt - fe0, 1);
        check("break_no_ce", ce_cnt, ce0);
        send_byte(8'h27, 1'b1);
        idle(4);
        check("shutdown", sd_cnt - sd0, 1);
        sb_check("t4");

        // 5: argument timeout, then unknown opcode
        ce0 = ce_cnt; av0 = av_cnt;
        send_byte(8'h28, 1'b1);
        waited = 0;
        while (ce_cnt == ce0 && waited < 2 * TMO) begin
            idle(1);
            waited++;
        end
        check("tmo_seen", ce_cnt - ce0, 1);
        check("tmo_delay", ce_cyc - dv_cyc, TMO);
        check("tmo_aux_kept", o_aux, 8'h25);
        send_byte(8'h99, 1'b1);
        idle(4);
        check("unknown_op_ce", ce_cnt - ce0, 2);
        check("unknown_op_no_av", av_cnt, av0);
        sb_check("t5");

        // 5b: framing error while waiting for argument
        fe0 = fe_cnt; ce0 = ce_cnt;
        send_byte(8'h28, 1'b1);
        send_byte(8'h3C, 1'b0);
        idle(10);
        check("argfe_fe", fe_cnt - fe0, 1);
        check("argfe_ce", ce_cnt - ce0, 1);
        check("argfe_same_cycle", fe_cyc, ce_cyc);
        check("argfe_aux_kept", o_aux, 8'h25);
        send_byte(8'h25, 1'b1);
        idle(4);
        check("argfe_back_to_cmd", o_ptt_req, 1);
        check("argfe_aux_after", o_aux, 8'h25);
        sb_check("t5b");

        // 6: reset during bit 4 of 0x25
        dv0 = dv_cnt; fe0 = fe_cnt; ce0 = ce_cnt;
        mcu_uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            mcu_uart_rx = (8'h25 >> i) & 1'b1;
            idle(BIT);
        end
        mcu_uart_rx = 1'b0;
        idle(BIT / 2);
        i_Rst_L = 1'b0;
        idle(3);
        mcu_uart_rx = 1'b1;
        idle(2);
        i_Rst_L = 1'b1;
        idle(1);
        check("rst2_outs", {o_rx_byte, o_aux, o_rx_dv, o_frame_err, o_ptt_req,
                            o_shutdown_req, o_aux_valid, o_cmd_err}, 0);
        idle(300);
        check("rst2_no_dv", dv_cnt, dv0);
        check("rst2_no_err", (fe_cnt - fe0) + (ce_cnt - ce0), 0);
        send_byte(8'h25, 1'b1);
        idle(4);
        check("rst2_ptt", o_ptt_req, 1);
        sb_check("t6");

        check("no_stretch", stretch, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
